dso_trigger_ctrl: RTL

Trigger controller for the DSO acquisition path: watches the ADC sample stream and the acquisition engine's `waiting_for_trigger` status, and drives the engine's `trigger_req` input. It implements level/slope triggering with hysteresis plus the normal, auto (timeout), immediate and single-shot modes. It sits between the ADC data bus / SPI-written configuration registers and the acquisition engine.

---
 rtl/dso_trigger_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/dso_trigger_ctrl.sv
// DSO trigger controller: level/slope trigger with hysteresis and
// normal / auto-timeout / immediate / single-shot modes.
module dso_trigger_ctrl #(
  parameter int DATA_W = 8,
  parameter int TMO_W  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_en,
  input  logic [DATA_W-1:0] adc_data,
  input  logic [DATA_W-1:0] level,
  input  logic [DATA_W-1:0] hyst,
  input  logic              slope,
  input  logic [1:0]        mode,
  input  logic [TMO_W-1:0]  auto_timeout,
  input  logic              arm,
  input  logic              waiting_for_trigger,
  output logic              trigger_req,
  output logic              armed,
  output logic              auto_fired,
  output logic              single_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEEK,
    S_ARMED,
    S_FIRE,
    S_STOP
  } state_t;

  localparam logic [1:0] MODE_AUTO   = 2'd1;
  localparam logic [1:0] MODE_IMM    = 2'd2;
  localparam logic [1:0] MODE_SINGLE = 2'd3;

  state_t             state;
  state_t             state_nxt;
  logic               auto_nxt;
  logic [1:0]         mode_q;
  logic [TMO_W-1:0]   timer;
  logic [DATA_W:0]    lvl_minus;
  logic [DATA_W:0]    lvl_plus;
  logic [DATA_W-1:0]  arm_lvl;
  logic               arm_cond;
  logic               fire_cond;
  logic               timeout_hit;
  logic               seeking;

  // One extra bit catches under/overflow so the arm level saturates.
  assign lvl_minus = {1'b0, level} - {1'b0, hyst};
  assign lvl_plus  = {1'b0, level} + {1'b0, hyst};

  always_comb begin
    if (slope) arm_lvl = lvl_plus[DATA_W]  ? '1 : lvl_plus[DATA_W-1:0];
    else       arm_lvl = lvl_minus[DATA_W] ? '0 : lvl_minus[DATA_W-1:0];
  end

  assign arm_cond    = slope ? (adc_data >= arm_lvl) : (adc_data <= arm_lvl);
  assign fire_cond   = slope ? (adc_data <= level)   : (adc_data >= level);
  assign seeking     = (state == S_SEEK) || (state == S_ARMED);
  assign timeout_hit = (mode_q == MODE_AUTO) && (timer == auto_timeout);

  always_comb begin
    // NOTE: every variable gets a default first so no latch is inferred.
    state_nxt = state;
    auto_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (waiting_for_trigger) state_nxt = (mode == MODE_IMM) ? S_FIRE : S_SEEK;
      end
      S_SEEK, S_ARMED: begin
        if (!waiting_for_trigger) begin
          state_nxt = S_IDLE;
        end else if (timeout_hit) begin
          state_nxt = S_FIRE;
          auto_nxt  = 1'b1;
        end else if (sample_en && state == S_SEEK && arm_cond) begin
          state_nxt = S_ARMED;
        end else if (sample_en && state == S_ARMED && fire_cond) begin
          state_nxt = S_FIRE;
        end
      end
      S_FIRE: begin
        if (!waiting_for_trigger) state_nxt = (mode_q == MODE_SINGLE) ? S_STOP : S_IDLE;
      end
      S_STOP: begin
        // Live mode here: leaving single mode releases a parked capture.
        if (arm || mode != MODE_SINGLE) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      mode_q      <= '0;
      timer       <= '0;
      trigger_req <= 1'b0;
      armed       <= 1'b0;
      auto_fired  <= 1'b0;
      single_done <= 1'b0;
    end else begin
      state       <= state_nxt;
      trigger_req <= (state_nxt == S_FIRE);
      armed       <= (state_nxt == S_ARMED);
      single_done <= (state_nxt == S_STOP);
      auto_fired  <= auto_nxt;
      if (state == S_IDLE && waiting_for_trigger) begin
        mode_q <= mode;
        timer  <= '0;
      end else if (seeking && mode_q == MODE_AUTO && !timeout_hit) begin
        timer <= timer + 1'b1;
      end
    end
  end

endmodule
